// File: rtl/fsm_ordered_merge_if.sv
// Handshake bundle between the ordered-merge controller, its producer
// channels and the shared output FIFO.
interface fsm_ordered_merge_if #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 10
);
    logic                    soft_clr;
    logic                    out_fifo_full;
    logic                    out_fifo_clr;
    logic                    out_fifo_push;
    logic [NUM_CH-1:0]       ch_data_valid;
    logic [NUM_CH*IDX_W-1:0] ch_index_q;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH-1:0]       ch_data_accepted;
    logic [IDX_W-1:0]        out_index;
    logic                    stall_err;

    // Controller side: reads producer/FIFO status, drives selects and strobes
    modport master (
        input  soft_clr, out_fifo_full, ch_data_valid, ch_index_q,
        output out_fifo_clr, out_fifo_push, ch_enable, ch_data_accepted,
               out_index, stall_err
    );

    // Environment side: producers and FIFO
    modport slave (
        output soft_clr, out_fifo_full, ch_data_valid, ch_index_q,
        input  out_fifo_clr, out_fifo_push, ch_enable, ch_data_accepted,
               out_index, stall_err
    );
endinterface

// File: rtl/fsm_ordered_merge.sv
// Ordered-merge controller: pushes head items from NUM_CH producer channels
// into a shared output FIFO strictly in sequence-index order. A channel is
// granted when its head index equals the current output index (cur) or the
// one after it (nxt, which also advances the index). Ties are broken
// round-robin. Includes a sticky stall detector and a soft clear.
module fsm_ordered_merge #(
    parameter int NUM_CH      = 4,
    parameter int IDX_W       = 10,
    parameter int IDX_MAX     = 2**IDX_W - 1,
    parameter int STALL_LIMIT = 256
) (
    input  logic                clk,
    input  logic                reset_n,
    fsm_ordered_merge_if.master bus
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SC_W = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(IDX_MAX);
    localparam logic [SC_W-1:0]  SC_LIMIT    = SC_W'(STALL_LIMIT);
    localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(NUM_CH - 1);
    localparam logic [CH_W:0]    NUM_CH_EXT  = (CH_W + 1)'(NUM_CH);

    typedef enum logic [3:0] {
        INIT      = 4'b0001,
        WAIT_DATA = 4'b0010,
        PUSH      = 4'b0100,
        OF_FULL   = 4'b1000
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [CH_W-1:0]   r_sel_ch;
    logic [CH_W-1:0]   r_rr_ptr;
    logic              r_inc_flag;
    logic [IDX_W-1:0]  r_out_index;
    logic [SC_W-1:0]   r_stall_cnt;
    logic              r_stall_err;

    logic [IDX_W-1:0]  w_idx_plus1;
    logic [NUM_CH-1:0] w_cur;
    logic [NUM_CH-1:0] w_nxt;
    logic [NUM_CH-1:0] w_pick_set;
    logic [NUM_CH-1:0] w_rot;
    logic [CH_W-1:0]   w_offset;
    logic [CH_W:0]     w_sum;
    logic [CH_W-1:0]   w_grant_ch;
    logic              w_any_cur;
    logic              w_any_cand;
    logic              w_any_valid;
    logic              w_grant_nxt;
    logic              w_load_sel;
    logic              w_clear;

    // Classify each channel head as matching the current or the next index
    always_comb begin
        w_idx_plus1 = (r_out_index == IDX_LAST) ? '0 : r_out_index + 1'b1;
        w_cur       = '0;
        w_nxt       = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_cur[k] = bus.ch_data_valid[k] &&
                       (bus.ch_index_q[k*IDX_W +: IDX_W] == r_out_index);
            w_nxt[k] = bus.ch_data_valid[k] &&
                       (bus.ch_index_q[k*IDX_W +: IDX_W] == w_idx_plus1);
        end
    end

    // Pick the winning set (cur beats nxt) and the first member at or after rr_ptr
    always_comb begin
        w_any_cur   = |w_cur;
        w_any_cand  = w_any_cur | (|w_nxt);
        w_any_valid = |bus.ch_data_valid;
        w_grant_nxt = !w_any_cur;
        w_pick_set  = w_any_cur ? w_cur : w_nxt;
        w_rot       = NUM_CH'({w_pick_set, w_pick_set} >> r_rr_ptr);
        w_offset    = '0;
        for (int j = NUM_CH - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                w_offset = CH_W'(j);
            end
        end
        w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_offset};
        w_grant_ch = (w_sum >= NUM_CH_EXT) ? CH_W'(w_sum - NUM_CH_EXT) : CH_W'(w_sum);
    end

    // Next-state decode and Moore outputs from the registered state
    always_comb begin
        w_next_state = r_state;
        w_load_sel   = 1'b0;
        case (r_state)
            INIT: begin
                w_next_state = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (w_any_cand) begin
                    if (bus.out_fifo_full) begin
                        w_next_state = OF_FULL;
                    end else begin
                        w_next_state = PUSH;
                        w_load_sel   = 1'b1;
                    end
                end
            end
            PUSH: begin
                w_next_state = WAIT_DATA;
            end
            OF_FULL: begin
                if (!bus.out_fifo_full) begin
                    if (w_any_cand) begin
                        w_next_state = PUSH;
                        w_load_sel   = 1'b1;
                    end else begin
                        w_next_state = WAIT_DATA;
                    end
                end
            end
            default: begin
                w_next_state = INIT;
            end
        endcase
        if (bus.soft_clr) begin
            w_next_state = INIT;
            w_load_sel   = 1'b0;
        end
        w_clear = (r_state == INIT) || (w_next_state == INIT);

        bus.out_fifo_clr     = (r_state == INIT);
        bus.out_fifo_push    = (r_state == PUSH);
        bus.ch_enable        = (r_state == PUSH) ? (NUM_CH'(1) << r_sel_ch) : '0;
        bus.ch_data_accepted = (r_state == PUSH) ? (NUM_CH'(1) << r_sel_ch) : '0;
        bus.out_index        = r_out_index;
        bus.stall_err        = r_stall_err;
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Grant latch, output index advance and round-robin pointer update
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel_ch    <= '0;
            r_inc_flag  <= 1'b0;
            r_out_index <= '0;
            r_rr_ptr    <= '0;
        end else begin
            if (w_load_sel) begin
                r_sel_ch   <= w_grant_ch;
                r_inc_flag <= w_grant_nxt;
            end
            if (w_clear) begin
                r_out_index <= '0;
                r_rr_ptr    <= '0;
            end else if (r_state == PUSH) begin
                if (r_inc_flag) begin
                    r_out_index <= w_idx_plus1;
                end
                r_rr_ptr <= (r_sel_ch == CH_LAST) ? '0 : r_sel_ch + 1'b1;
            end
        end
    end

    // Stall detector: counts WAIT_DATA cycles with data pending but nothing grantable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else if (w_clear) begin
            r_stall_cnt <= '0;
            r_stall_err <= 1'b0;
        end else if (!w_any_valid || (r_state == PUSH) ||
                     ((r_state == WAIT_DATA) && w_any_cand)) begin
            r_stall_cnt <= '0;
        end else if ((r_state == WAIT_DATA) && (STALL_LIMIT != 0) &&
                     (r_stall_cnt != SC_LIMIT)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
            if (r_stall_cnt == SC_LIMIT - 1'b1) begin
                r_stall_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fsm_ordered_merge.sv
// Directed bench for fsm_ordered_merge with a scoreboard: every expected push
// (channel, out_index during the push) is queued when stimulus is issued and
// an independent monitor pops and compares whenever the DUT pushes.
module tb_fsm_ordered_merge;
    localparam int NUM_CH      = 4;
    localparam int IDX_W       = 4;
    localparam int STALL_LIMIT = 8;

    typedef struct packed {
        int ch;
        int idx;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];

    fsm_ordered_merge_if #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) bus ();

    fsm_ordered_merge #(
        .NUM_CH     (NUM_CH),
        .IDX_W      (IDX_W),
        .IDX_MAX    (15),
        .STALL_LIMIT(STALL_LIMIT)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Single comparison point; every check steps the counters here
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one producer channel's head valid/index
    task automatic applyStimulus(input int k, input bit v, input int idx);
        bus.ch_data_valid[k]              = v;
        bus.ch_index_q[k*IDX_W +: IDX_W]  = IDX_W'(idx);
    endtask

    task automatic expectPush(input int ch, input int idx);
        exp_t e;
        e.ch  = ch;
        e.idx = idx;
        expQ.push_back(e);
    endtask

    // Wait (bounded) for the next push; returns the number of negedges waited
    task automatic waitPush(input string name, output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!bus.out_fifo_push && cycles < 20);
        if (!bus.out_fifo_push) begin
            checkOutput(name, int'(bus.out_fifo_push), 1);
        end
    endtask

    // Scoreboard monitor: compares every push against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1 && bus.out_fifo_push === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedPush", int'(bus.out_fifo_push), 0);
            end else begin
                e = expQ.pop_front();
                checkOutput("pushEnable", int'(bus.ch_enable), 1 << e.ch);
                checkOutput("pushAccepted", int'(bus.ch_data_accepted), 1 << e.ch);
                checkOutput("pushIndex", int'(bus.out_index), e.idx);
            end
        end
    end

    initial begin
        int cyc;
        int pushes;
        int clrSeen;

        reset_n            = 1'b0;
        bus.soft_clr       = 1'b0;
        bus.out_fifo_full  = 1'b0;
        bus.ch_data_valid  = '0;
        bus.ch_index_q     = '0;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rstClr", int'(bus.out_fifo_clr), 1);
        checkOutput("rstPush", int'(bus.out_fifo_push), 0);
        checkOutput("rstEnable", int'(bus.ch_enable), 0);
        checkOutput("rstIndex", int'(bus.out_index), 0);
        checkOutput("rstStallErr", int'(bus.stall_err), 0);
        reset_n = 1'b1;
        #1 checkOutput("initAfterRelease", int'(bus.out_fifo_clr), 1);
        @(negedge clk);
        checkOutput("waitAfterInit", int'(bus.out_fifo_clr), 0);

        // Climb out_index 0 -> 5 with nxt grants on ch0
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(0, 1'b1, i);
            expectPush(0, i - 1);
            waitPush("climbTimeout", cyc);
            if (i == 1) checkOutput("pushLatency", cyc, 1);
        end
        applyStimulus(0, 1'b0, 0);
        @(negedge clk);
        checkOutput("climbIndex", int'(bus.out_index), 5);

        // Ordering: ch0 at 5 (cur) before ch2 at 6 (nxt)
        applyStimulus(2, 1'b1, 6);
        applyStimulus(0, 1'b1, 5);
        expectPush(0, 5);
        expectPush(2, 5);
        waitPush("order0Timeout", cyc);
        applyStimulus(0, 1'b0, 0);
        waitPush("order2Timeout", cyc);
        applyStimulus(2, 1'b0, 0);
        @(negedge clk);
        checkOutput("orderIndex", int'(bus.out_index), 6);

        // Round-robin: ch1 and ch3 both cur at 6, rr_ptr=3 -> 3,1,3,1
        applyStimulus(1, 1'b1, 6);
        applyStimulus(3, 1'b1, 6);
        expectPush(3, 6);
        expectPush(1, 6);
        expectPush(3, 6);
        expectPush(1, 6);
        repeat (4) waitPush("rrTimeout", cyc);
        applyStimulus(1, 1'b0, 0);
        applyStimulus(3, 1'b0, 0);
        @(negedge clk);
        checkOutput("rrIndex", int'(bus.out_index), 6);

        // FIFO full for 10 cycles with ch1 a candidate
        bus.out_fifo_full = 1'b1;
        applyStimulus(1, 1'b1, 6);
        pushes = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_fifo_push) pushes++;
        end
        checkOutput("fullNoPush", pushes, 0);
        bus.out_fifo_full = 1'b0;
        expectPush(1, 6);
        waitPush("fullReleaseTimeout", cyc);
        checkOutput("fullReleaseLatency", cyc, 1);
        applyStimulus(1, 1'b0, 0);
        @(negedge clk);

        // Candidate withdrawn while full: back to WAIT_DATA, no push, no INIT
        bus.out_fifo_full = 1'b1;
        applyStimulus(1, 1'b1, 6);
        repeat (3) @(negedge clk);
        applyStimulus(1, 1'b0, 0);
        repeat (2) @(negedge clk);
        bus.out_fifo_full = 1'b0;
        pushes  = 0;
        clrSeen = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_fifo_push) pushes++;
            if (bus.out_fifo_clr) clrSeen++;
        end
        checkOutput("abandonNoPush", pushes, 0);
        checkOutput("abandonNoInit", clrSeen, 0);
        applyStimulus(1, 1'b1, 6);
        expectPush(1, 6);
        waitPush("abandonTimeout", cyc);
        checkOutput("abandonLatency", cyc, 1);
        applyStimulus(1, 1'b0, 0);

        // Climb 6 -> 15, then index 0 is nxt of 15 and wraps out_index to 0
        for (int i = 7; i <= 16; i++) begin
            applyStimulus(0, 1'b1, i % 16);
            expectPush(0, i - 1);
            waitPush("wrapTimeout", cyc);
        end
        applyStimulus(0, 1'b0, 0);
        @(negedge clk);
        checkOutput("wrapIndex", int'(bus.out_index), 0);

        // Move to out_index 2, then stall with ch0 waiting at index 6
        for (int i = 1; i <= 2; i++) begin
            applyStimulus(0, 1'b1, i);
            expectPush(0, i - 1);
            waitPush("preStallTimeout", cyc);
        end
        applyStimulus(0, 1'b0, 0);
        @(negedge clk);
        checkOutput("preStallIndex", int'(bus.out_index), 2);
        applyStimulus(0, 1'b1, 6);
        repeat (7) @(negedge clk);
        checkOutput("stallErrEarly", int'(bus.stall_err), 0);
        @(negedge clk);
        checkOutput("stallErrSet", int'(bus.stall_err), 1);
        repeat (4) @(negedge clk);
        applyStimulus(0, 1'b0, 0);
        repeat (2) @(negedge clk);
        checkOutput("stallErrSticky", int'(bus.stall_err), 1);

        // soft_clr together with a cur candidate: soft_clr wins
        applyStimulus(0, 1'b1, 2);
        bus.soft_clr = 1'b1;
        @(negedge clk);
        checkOutput("softClrNoPush", int'(bus.out_fifo_push), 0);
        checkOutput("softClrInit", int'(bus.out_fifo_clr), 1);
        checkOutput("softClrStallErr", int'(bus.stall_err), 0);
        checkOutput("softClrIndex", int'(bus.out_index), 0);
        bus.soft_clr = 1'b0;
        applyStimulus(0, 1'b0, 0);
        @(negedge clk);
        checkOutput("softClrOneInit", int'(bus.out_fifo_clr), 0);

        // Reset asserted in the middle of a PUSH
        applyStimulus(1, 1'b1, 1);
        expectPush(1, 0);
        waitPush("midPushTimeout", cyc);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("midRstPush", int'(bus.out_fifo_push), 0);
        checkOutput("midRstEnable", int'(bus.ch_enable), 0);
        checkOutput("midRstAccepted", int'(bus.ch_data_accepted), 0);
        checkOutput("midRstClr", int'(bus.out_fifo_clr), 1);
        checkOutput("midRstIndex", int'(bus.out_index), 0);
        applyStimulus(1, 1'b0, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 checkOutput("midRstInit", int'(bus.out_fifo_clr), 1);
        @(negedge clk);
        checkOutput("midRstWait", int'(bus.out_fifo_clr), 0);
        checkOutput("midRstIndexAfter", int'(bus.out_index), 0);

        checkOutput("scoreboardEmpty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
